char_stream_tx: RTL and testbench

CHAR_STREAM_TX -- requirements
Module: char_stream_tx

---
 rtl/char_stream_tx_pkg.sv | 7 +
 rtl/char_stream_tx_chr_shifter.sv | 26 ++
 rtl/char_stream_tx.sv | 89 ++++++++
 tb/tb_char_stream_tx.sv | 121 ++++++++++++
 4 files changed

// File: rtl/char_stream_tx_pkg.sv
// char_stream_tx_pkg: shared FSM state type and default string length for char_stream_tx.
//   state_t    : IDLE, SEND, DRAIN, DONE
//   MAXLEN_DEF : default maximum string length (characters)
package char_stream_tx_pkg;
    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;
    localparam int MAXLEN_DEF = 16;
endpackage

// File: rtl/char_stream_tx_chr_shifter.sv
// chr_shifter: holds the latched string and presents the current character on cur.
//   clk, reset(active-low async) : clock and reset
//   load  : capture data (bit 0 is presented first)
//   shift : advance to the next character
//   data  : string to capture
//   cur   : current character
module chr_shifter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         cur
);
    logic [W-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else if (load) q <= data;
        else if (shift) q <= q >> 1;
    end

    assign cur = q[0];
endmodule

// File: rtl/char_stream_tx.sv
// char_stream_tx: streams a loaded 1-bit-character string into a matcher and collects its match results.
//   clk, reset(active-low async)    : clock and reset
//   ld_valid/ld_ready/ld_data/ld_len : string load handshake (ld_len clamped to MAXLEN)
//   tok, chr                        : start token and current character to the matcher
//   m_in                            : matcher output, one cycle behind chr
//   done                            : one-cycle pulse at string end
//   match, first_pos, match_cnt     : results, held until the next load
// Build option: CHAR_STREAM_TX_UNANCHORED_EN drives tok on every SEND cycle (substring search);
// otherwise tok is only asserted on the first character (anchored match).
module char_stream_tx
    import char_stream_tx_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [MAXLEN-1:0] ld_data,
    input  logic [LW-1:0]     ld_len,
    output logic              tok,
    output logic              chr,
    input  logic              m_in,
    output logic              done,
    output logic              match,
    output logic [LW-1:0]     first_pos,
    output logic [LW-1:0]     match_cnt
);
    localparam logic [LW-1:0] MAXL = LW'(MAXLEN);

    state_t        state, state_nxt;
    logic [LW-1:0] t, len;
    logic          accept, sample, cur;

    assign accept = state == IDLE && ld_valid;
    // m_in reports prefix length t one cycle late, so t=0 carries nothing and DRAIN carries the last one
    assign sample = m_in && ((state == SEND && t != '0) || state == DRAIN);

    always_comb begin
        state_nxt = state == IDLE  ? (ld_valid ? (ld_len == '0 ? DONE : SEND) : IDLE) :
                    state == SEND  ? (t == len - LW'(1) ? DRAIN : SEND) :
                    state == DRAIN ? DONE : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            t         <= '0;
            len       <= '0;
            match     <= 1'b0;
            first_pos <= '0;
            match_cnt <= '0;
        end else begin
            state <= state_nxt;
            t     <= accept ? '0 : state == SEND ? t + LW'(1) : t;
            if (accept) begin
                len       <= ld_len > MAXL ? MAXL : ld_len;
                match     <= 1'b0;
                first_pos <= '0;
                match_cnt <= '0;
            end else if (sample) begin
                match_cnt <= match_cnt + LW'(1);
                if (!match) begin
                    match     <= 1'b1;
                    first_pos <= t;
                end
            end
        end
    end

    chr_shifter #(.W(MAXLEN)) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (state == SEND),
        .data  (ld_data),
        .cur   (cur)
    );

    assign ld_ready = state == IDLE;
    assign done     = state == DONE;
    assign chr      = state == SEND && cur;
`ifdef CHAR_STREAM_TX_UNANCHORED_EN
    assign tok      = state == SEND;
`else
    assign tok      = state == SEND && t == '0;
`endif
endmodule

// File: tb/tb_char_stream_tx.sv
// tb_char_stream_tx: randomized self-checking bench for char_stream_tx against a cycle-indexed string model.
module tb_char_stream_tx;
    localparam int MAXLEN = 16;
    localparam int LW     = $clog2(MAXLEN + 1);

    logic              clk = 0, reset = 1, ld_valid = 0, m_in = 0;
    logic [MAXLEN-1:0] ld_data = '0;
    logic [LW-1:0]     ld_len = '0;
    logic              ld_ready, tok, chr, done, match;
    logic [LW-1:0]     first_pos, match_cnt;
    int                tests = 0, fails = 0;

    always #5 clk = ~clk;

    char_stream_tx #(.MAXLEN(MAXLEN)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_len(ld_len), .tok(tok), .chr(chr), .m_in(m_in),
        .done(done), .match(match), .first_pos(first_pos), .match_cnt(match_cnt)
    );

    task automatic chk(input string tag, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Cycle k counts from the first cycle after accept; m[k] is the matcher output driven in cycle k.
    task automatic run_string(input logic [MAXLEN-1:0] d, input int len, input logic [63:0] m, input bit noise);
        int  l, n, em, ef, ec;
        bit  send, drain, unanch;
        l  = len > MAXLEN ? MAXLEN : len;
        n  = l == 0 ? 1 : l + 2;
        em = 0; ef = 0; ec = 0;
`ifdef CHAR_STREAM_TX_UNANCHORED_EN
        unanch = 1;
`else
        unanch = 0;
`endif
        @(negedge clk);
        chk("ready_idle", ld_ready, 1);
        ld_valid = 1; ld_data = d; ld_len = LW'(len); m_in = 1'($urandom);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            ld_valid = noise ? 1'($urandom) : 1'b0;
            ld_data  = MAXLEN'($urandom);
            ld_len   = LW'($urandom);
            m_in     = m[k];
            send  = l > 0 && k < l;
            drain = l > 0 && k == l;
            chk("tok", tok, int'(send && (unanch || k == 0)));
            chk("chr", chr, send ? int'(d[k]) : 0);
            chk("done", done, int'(k == n - 1));
            chk("ready_busy", ld_ready, 0);
            chk("match_run", match, em);
            chk("first_run", first_pos, ef);
            chk("cnt_run", match_cnt, ec);
            if (((send && k >= 1) || drain) && m[k]) begin
                ec++;
                if (em == 0) begin em = 1; ef = k; end
            end
            @(negedge clk);
        end
        ld_valid = 0;
        chk("done_low", done, 0);
        chk("ready_back", ld_ready, 1);
        chk("match_hold", match, em);
        chk("first_hold", first_pos, ef);
        chk("cnt_hold", match_cnt, ec);
    endtask

    initial begin
        #2 reset = 0;
        #1;
        chk("rst_ready", ld_ready, 1);
        chk("rst_outs", {tok, chr, done, match, first_pos, match_cnt}, 0);
        @(negedge clk);
        reset = 1;

        run_string(16'b1010, 4, 64'h0, 0);
        chk("d036_match", match, 0);
        chk("d036_cnt", match_cnt, 0);
        run_string(16'h0005, 3, 64'b1100, 0);
        chk("d037_match", match, 1);
        chk("d037_first", first_pos, 2);
        chk("d037_cnt", match_cnt, 2);
        run_string(16'hffff, 0, 64'hffff, 0);
        chk("d038_match", match, 0);
        run_string(16'hbeef, 20, 64'h1, 0);
        chk("d039_match", match, 0);
        run_string(16'h000f, 4, 64'h0, 0);

        // reset in the middle of a len=8 string after one match has been recorded
        @(negedge clk);
        ld_valid = 1; ld_data = 16'h00a5; ld_len = LW'(8);
        @(negedge clk);
        ld_valid = 0; m_in = 0;
        @(negedge clk);
        m_in = 1;
        @(negedge clk);
        chk("pre_rst_cnt", match_cnt, 1);
        reset = 0;
        #1;
        chk("mid_rst_ready", ld_ready, 1);
        chk("mid_rst_outs", {tok, chr, done, match, first_pos, match_cnt}, 0);
        m_in = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        reset = 1;
        run_string(16'h3c3c, 8, 64'b1_0010_0100, 0);

        for (int i = 0; i < 40; i++)
            run_string(MAXLEN'($urandom), int'($urandom_range(0, MAXLEN + 4)), {$urandom, $urandom}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
